// File: rtl/mac_tile_simd.sv
// Weight-stationary MAC tile with two signed weights: one full-width psum, or two half-width SIMD lanes.
// Optional ZERO_GATE_EN: holds multiplier operands on zero a/weight and adds the `gated` output.
module mac_tile_simd #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw-1:0]      in_w,
    input  logic [2:0]         inst_w,
    input  logic [psum_bw-1:0] in_n,
    output logic [bw-1:0]      out_e,
    output logic [2:0]         inst_e,
    output logic [psum_bw-1:0] out_s
`ifdef ZERO_GATE_EN
    ,
    output logic               gated
`endif
);
    localparam int hw = psum_bw / 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } load_state_t;

    load_state_t state, state_next;

    logic signed [bw-1:0] b0, b1;
    logic load, exec, simd;
    logic wr_b0, wr_b1, fwd_load;

    assign load = inst_w[0];
    assign exec = inst_w[1];
    assign simd = inst_w[2];

    // Execute takes priority, so a combined load/execute never touches weights.
    always_comb begin
        state_next = state;
        wr_b0      = 1'b0;
        wr_b1      = 1'b0;
        fwd_load   = 1'b0;
        if (load && !exec) begin
            case (state)
                FULL: fwd_load = 1'b1;
                HALF: begin
                    wr_b1      = 1'b1;
                    wr_b0      = !simd;
                    state_next = FULL;
                end
                default: begin
                    wr_b0      = 1'b1;
                    wr_b1      = !simd;
                    state_next = simd ? HALF : FULL;
                end
            endcase
        end
    end

    logic [bw-1:0] a0_op, a1_op, b0_op, b1_op;
    logic          gate0, gate1;

`ifdef ZERO_GATE_EN
    logic [bw-1:0] a0_hold, a1_hold, b0_hold, b1_hold;

    // Lane 1 is idle outside SIMD, so it always counts as gated there.
    assign gate0 = (in_w == '0) || (b0 == '0);
    assign gate1 = !simd || (in_w == '0) || (b1 == '0);
    assign a0_op = gate0 ? a0_hold : in_w;
    assign b0_op = gate0 ? b0_hold : b0;
    assign a1_op = gate1 ? a1_hold : in_w;
    assign b1_op = gate1 ? b1_hold : b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            a0_hold <= '0;
            b0_hold <= '0;
            a1_hold <= '0;
            b1_hold <= '0;
            gated   <= 1'b0;
        end else begin
            gated <= exec && gate0 && gate1;
            if (exec && !gate0) begin
                a0_hold <= in_w;
                b0_hold <= b0;
            end
            if (exec && !gate1) begin
                a1_hold <= in_w;
                b1_hold <= b1;
            end
        end
    end
`else
    assign gate0 = 1'b0;
    assign gate1 = 1'b0;
    assign a0_op = in_w;
    assign b0_op = b0;
    assign a1_op = in_w;
    assign b1_op = b1;
`endif

    // Products are formed in lane width; |a*b| < 2^(2*bw-1) so nothing is lost.
    logic [hw-1:0] a0_x, a1_x, b0_x, b1_x, p0, p1;
    logic [hw-1:0] lane0_sum, lane1_sum;
    logic [psum_bw-1:0] full_sum;

    assign a0_x = {{(hw-bw){1'b0}}, a0_op};
    assign a1_x = {{(hw-bw){1'b0}}, a1_op};
    assign b0_x = {{(hw-bw){b0_op[bw-1]}}, b0_op};
    assign b1_x = {{(hw-bw){b1_op[bw-1]}}, b1_op};
    assign p0   = gate0 ? '0 : a0_x * b0_x;
    assign p1   = gate1 ? '0 : a1_x * b1_x;

    assign full_sum  = in_n + {{hw{p0[hw-1]}}, p0};
    assign lane0_sum = in_n[hw-1:0] + p0;
    assign lane1_sum = in_n[psum_bw-1:hw] + p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            b0     <= '0;
            b1     <= '0;
            out_e  <= '0;
            inst_e <= '0;
            out_s  <= '0;
        end else begin
            state  <= state_next;
            if (wr_b0) b0 <= in_w;
            if (wr_b1) b1 <= in_w;
            out_e  <= in_w;
            inst_e <= {simd, exec, fwd_load};
            if (exec) out_s <= simd ? {lane1_sum, lane0_sum} : full_sum;
        end
    end
endmodule
